// File: rtl/int_mul_rad4_pkg.sv
// Shared constants for the radix-4 multiplier: state encodings and
// datapath mux-select values used by both control and datapath.
package int_mul_rad4_pkg;

    localparam int STATE_IDLE = 0;
    localparam int STATE_DONE = 1;

    localparam logic SEL_LOAD = 1'b0;
    localparam logic SEL_STEP = 1'b1;

    localparam logic A_SEL_LOAD    = SEL_LOAD;
    localparam logic A_SEL_SHIFT   = SEL_STEP;
    localparam logic B_SEL_LOAD    = SEL_LOAD;
    localparam logic B_SEL_SHIFT   = SEL_STEP;
    localparam logic ACC_SEL_CLEAR = SEL_LOAD;
    localparam logic ACC_SEL_ADD   = SEL_STEP;

    function automatic int calc_entry(input int nbits);
        return 1 + nbits / 2;
    endfunction

    function automatic int state_width(input int nbits);
        return 1 + $clog2(nbits);
    endfunction

endpackage

// File: rtl/int_mul_rad4_dpath.sv
// Datapath: multiplicand/multiplier shift registers and a two-partial-product
// accumulator, steered entirely by control selects and enables.
module int_mul_rad4_dpath
    import int_mul_rad4_pkg::*;
#(
    parameter int nbits = 64
) (
    input  logic               clk,
    input  logic [2*nbits-1:0] req_msg,
    input  logic               a_sel,
    input  logic               b_sel,
    input  logic               acc_sel,
    input  logic               a_en,
    input  logic               b_en,
    input  logic               acc_en,
    output logic [2*nbits-1:0] resp_msg
);

    logic [2*nbits-1:0] a_q, a_d;
    logic [nbits-1:0]   b_q, b_d;
    logic [2*nbits-1:0] acc_q, acc_d;
    logic [2*nbits-1:0] pp0, pp1, sum;

    always_comb begin
        pp0 = b_q[0] ? a_q : '0;
        pp1 = b_q[1] ? {a_q[2*nbits-2:0], 1'b0} : '0;
        // Wraps modulo 2^(2*nbits); the true product always fits.
        sum = acc_q + pp0 + pp1;

        a_d   = (a_sel == A_SEL_SHIFT) ? {a_q[2*nbits-3:0], 2'b00}
                                       : {{nbits{1'b0}}, req_msg[2*nbits-1:nbits]};
        b_d   = (b_sel == B_SEL_SHIFT) ? {2'b00, b_q[nbits-1:2]}
                                       : req_msg[nbits-1:0];
        acc_d = (acc_sel == ACC_SEL_ADD) ? sum : '0;
    end

    always_ff @(posedge clk) begin
        if (a_en)   a_q   <= a_d;
        if (b_en)   b_q   <= b_d;
        if (acc_en) acc_q <= acc_d;
    end

    assign resp_msg = acc_q;

endmodule

// File: rtl/int_mul_rad4.sv
// Radix-4 iterative unsigned multiplier: fixed-latency control built on a
// down-counting state register (IDLE=0, DONE=1, CALC counts down to 2).
module int_mul_rad4
    import int_mul_rad4_pkg::*;
#(
    parameter int nbits = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2*nbits-1:0] req_msg,
    input  logic               req_val,
    output logic               req_rdy,
    output logic [2*nbits-1:0] resp_msg,
    output logic               resp_val,
    input  logic               resp_rdy
);

    localparam int SW = state_width(nbits);
    localparam logic [SW-1:0] IDLE = SW'(STATE_IDLE);
    localparam logic [SW-1:0] DONE = SW'(STATE_DONE);
    localparam logic [SW-1:0] CALC = SW'(calc_entry(nbits));

    logic [SW-1:0] state_q, state_d;
    logic a_sel, b_sel, acc_sel, a_en, b_en, acc_en;

    always_comb begin
        state_d  = state_q;
        req_rdy  = 1'b0;
        resp_val = 1'b0;
        a_sel    = A_SEL_LOAD;
        b_sel    = B_SEL_LOAD;
        acc_sel  = ACC_SEL_CLEAR;
        a_en     = 1'b0;
        b_en     = 1'b0;
        acc_en   = 1'b0;

        if (state_q == IDLE) begin
            req_rdy = 1'b1;
            if (req_val) begin
                state_d = CALC;
                a_en    = 1'b1;
                b_en    = 1'b1;
                acc_en  = 1'b1;
            end
        end else if (state_q == DONE) begin
            resp_val = 1'b1;
            if (resp_rdy) state_d = IDLE;
        end else begin
            // Any state above DONE is a CALC step; the count doubles as the iteration counter.
            a_sel   = A_SEL_SHIFT;
            b_sel   = B_SEL_SHIFT;
            acc_sel = ACC_SEL_ADD;
            a_en    = 1'b1;
            b_en    = 1'b1;
            acc_en  = 1'b1;
            state_d = state_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    int_mul_rad4_dpath #(.nbits(nbits)) u_dpath (
        .clk      (clk),
        .req_msg  (req_msg),
        .a_sel    (a_sel),
        .b_sel    (b_sel),
        .acc_sel  (acc_sel),
        .a_en     (a_en),
        .b_en     (b_en),
        .acc_en   (acc_en),
        .resp_msg (resp_msg)
    );

endmodule
